// File: rtl/jg_pkg.sv
// jg_pkg: shared constants and helper functions for the Johnson/Gray counter slice.
// Functions take the Johnson word zero-extended to JW_MAX bits plus the real ring width.
package jg_pkg;
    localparam int JW_DEF = 4;
    localparam int JW_MAX = 64;

    function automatic int gw_of(input int jw);
        return $clog2(2 * jw);
    endfunction

    function automatic int bin2gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // A legal Johnson code has at most one 0/1 transition between adjacent bits.
    function automatic logic johnson_valid(input logic [JW_MAX-1:0] j, input int jw);
        int t;
        t = 0;
        for (int i = 0; i < jw - 1; i++)
            t += int'(j[i] ^ j[i+1]);
        return t <= 1;
    endfunction

    function automatic int johnson_to_index(input logic [JW_MAX-1:0] j, input int jw);
        int pc;
        pc = 0;
        for (int i = 0; i < jw; i++)
            pc += int'(j[i]);
        return j[jw-1] ? 2 * jw - pc : pc;
    endfunction
endpackage

// File: rtl/johnson_decode.sv
// johnson_decode: combinational Johnson-to-index/Gray converter for any ring width.
// Ports: johnson (in, JW) ring word; index/gray (out, GW) decoded position and its
// Gray code, both 0 for illegal words; illegal (out) word is not a valid Johnson code.
module johnson_decode
    import jg_pkg::*;
#(
    parameter int JW = JW_DEF,
    localparam int GW = gw_of(JW)
) (
    input  logic [JW-1:0] johnson,
    output logic [GW-1:0] index,
    output logic [GW-1:0] gray,
    output logic          illegal
);
    always_comb begin
        illegal = !johnson_valid(JW_MAX'(johnson), JW);
        index   = illegal ? '0 : GW'(johnson_to_index(JW_MAX'(johnson), JW));
        gray    = illegal ? '0 : GW'(bin2gray(int'(index)));
    end
endmodule

// File: rtl/johnson_gray_counter.sv
// johnson_gray_counter: up/down Johnson ring counter with Gray/index decode,
// illegal-code detection and self-recovery, sticky err and a registered wrap pulse.
// Ports: clk, rst_n (async active-low); en step enable; dir 1=up 0=down;
// clr sync clear (also clears err); ld/ld_j sync raw load; johnson ring state;
// index/gray decoded position; illegal state invalid; err sticky illegal flag;
// wrap one-cycle pulse after a wrapping step.
// Macro JG_OUT_REG_EN: registers index/gray/illegal (one cycle behind johnson)
// and delays wrap one extra cycle to stay aligned with gray.
module johnson_gray_counter
    import jg_pkg::*;
#(
    parameter int JW = JW_DEF,
    localparam int GW = gw_of(JW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          dir,
    input  logic          clr,
    input  logic          ld,
    input  logic [JW-1:0] ld_j,
    output logic [JW-1:0] johnson,
    output logic [GW-1:0] index,
    output logic [GW-1:0] gray,
    output logic          illegal,
    output logic          err,
    output logic          wrap
);
    logic [JW-1:0] j_q, j_d;
    logic [GW-1:0] d_index, d_gray;
    logic          d_illegal, wrap_d, wrap_q, err_q;

    johnson_decode #(.JW(JW)) u_dec (
        .johnson(j_q),
        .index  (d_index),
        .gray   (d_gray),
        .illegal(d_illegal)
    );

    // Stepping from an illegal word always recovers to zero, whatever dir says.
    always_comb begin
        j_d = clr ? '0 : ld ? ld_j : !en ? j_q : d_illegal ? '0 :
              dir ? {j_q[JW-2:0], ~j_q[JW-1]} : {~j_q[0], j_q[JW-1:1]};
        wrap_d = !clr && !ld && en && !d_illegal &&
                 (dir ? d_index == GW'(2 * JW - 1) : d_index == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_q    <= '0;
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            j_q    <= j_d;
            err_q  <= !clr && (err_q || d_illegal);
            wrap_q <= wrap_d;
        end
    end

    assign johnson = j_q;
    assign err     = err_q;

`ifdef JG_OUT_REG_EN
    logic [GW-1:0] index_q, gray_q;
    logic          illegal_q, wrap_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q   <= '0;
            gray_q    <= '0;
            illegal_q <= 1'b0;
            wrap_qq   <= 1'b0;
        end else begin
            index_q   <= d_index;
            gray_q    <= d_gray;
            illegal_q <= d_illegal;
            wrap_qq   <= wrap_q;
        end
    end

    assign index   = index_q;
    assign gray    = gray_q;
    assign illegal = illegal_q;
    assign wrap    = wrap_qq;
`else
    assign index   = d_index;
    assign gray    = d_gray;
    assign illegal = d_illegal;
    assign wrap    = wrap_q;
`endif
endmodule

// File: tb/tb_johnson_gray_counter.sv
// tb_johnson_gray_counter: scoreboard bench for johnson_gray_counter at JW=4 and JW=5.
module tb_johnson_gray_counter;
    typedef struct {
        logic       sel;
        logic [4:0] j;
        logic [3:0] idx;
        logic [3:0] g;
        logic       ill;
        logic       err;
        logic       w;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, dir = 1'b0, clr = 1'b0, ld = 1'b0, cur = 1'b0;
    logic [3:0] ld_j = '0;

    logic [3:0] j4;
    logic [2:0] idx4, g4;
    logic       ill4, err4, w4;
    logic [4:0] j5;
    logic [3:0] idx5, g5;
    logic       ill5, err5, w5;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t e;
    exp_t pv[2];

    always #5 clk = ~clk;

    johnson_gray_counter #(.JW(4)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en & ~cur), .dir(dir), .clr(clr & ~cur),
        .ld(ld & ~cur), .ld_j(ld_j), .johnson(j4), .index(idx4), .gray(g4),
        .illegal(ill4), .err(err4), .wrap(w4)
    );

    johnson_gray_counter #(.JW(5)) u5 (
        .clk(clk), .rst_n(rst_n), .en(en & cur), .dir(dir), .clr(clr & cur),
        .ld(ld & cur), .ld_j({1'b0, ld_j}), .johnson(j5), .index(idx5), .gray(g5),
        .illegal(ill5), .err(err5), .wrap(w5)
    );

    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, x);
        end
    endtask

    initial begin
        pv[0] = '{1'b0, 5'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "init"};
        pv[1] = pv[0];
    end

    always @(negedge rst_n) begin
        pv[0].idx = '0; pv[0].g = '0; pv[0].ill = 1'b0; pv[0].w = 1'b0;
        pv[1].idx = '0; pv[1].g = '0; pv[1].ill = 1'b0; pv[1].w = 1'b0;
    end

    // Monitor: one expectation per clock, compared on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            e = q.pop_front();
            x = e;
`ifdef JG_OUT_REG_EN
            x.idx = pv[e.sel].idx;
            x.g   = pv[e.sel].g;
            x.ill = pv[e.sel].ill;
            x.w   = pv[e.sel].w;
            pv[e.sel] = e;
`endif
            chk({e.nm, " johnson"}, e.sel ? 8'(j5)   : 8'(j4),   8'(x.j));
            chk({e.nm, " index"},   e.sel ? 8'(idx5) : 8'(idx4), 8'(x.idx));
            chk({e.nm, " gray"},    e.sel ? 8'(g5)   : 8'(g4),   8'(x.g));
            chk({e.nm, " illegal"}, e.sel ? 8'(ill5) : 8'(ill4), 8'(x.ill));
            chk({e.nm, " err"},     e.sel ? 8'(err5) : 8'(err4), 8'(x.err));
            chk({e.nm, " wrap"},    e.sel ? 8'(w5)   : 8'(w4),   8'(x.w));
        end
    end

    task automatic step(input logic r, input logic e_, input logic d, input logic c,
                        input logic l, input logic [3:0] lj, input logic s,
                        input logic [4:0] j, input logic [3:0] idx, input logic [3:0] g,
                        input logic ill, input logic er, input logic w, input string nm);
        exp_t x;
        @(negedge clk);
        #1;
        rst_n = r; en = e_; dir = d; clr = c; ld = l; ld_j = lj; cur = s;
        x = '{s, j, idx, g, ill, er, w, nm};
        q.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
    endtask

    initial begin
        // reset
        step(0,0,0,0,0,4'h0, 0, 5'b00000, 4'd0, 4'b0000, 0,0,0, "rst0");
        step(0,0,0,0,0,4'h0, 0, 5'b00000, 4'd0, 4'b0000, 0,0,0, "rst1");
        // JW=4 up count through wrap
        step(1,1,1,0,0,4'h0, 0, 5'b00001, 4'd1, 4'b0001, 0,0,0, "up1");
        step(1,1,1,0,0,4'h0, 0, 5'b00011, 4'd2, 4'b0011, 0,0,0, "up2");
        step(1,1,1,0,0,4'h0, 0, 5'b00111, 4'd3, 4'b0010, 0,0,0, "up3");
        step(1,1,1,0,0,4'h0, 0, 5'b01111, 4'd4, 4'b0110, 0,0,0, "up4");
        step(1,1,1,0,0,4'h0, 0, 5'b01110, 4'd5, 4'b0111, 0,0,0, "up5");
        step(1,1,1,0,0,4'h0, 0, 5'b01100, 4'd6, 4'b0101, 0,0,0, "up6");
        step(1,1,1,0,0,4'h0, 0, 5'b01000, 4'd7, 4'b0100, 0,0,0, "up7");
        step(1,1,1,0,0,4'h0, 0, 5'b00000, 4'd0, 4'b0000, 0,0,1, "upwrap");
        step(1,0,1,0,0,4'h0, 0, 5'b00000, 4'd0, 4'b0000, 0,0,0, "hold");
        // JW=4 down count wrapping backwards
        step(1,1,0,0,0,4'h0, 0, 5'b01000, 4'd7, 4'b0100, 0,0,1, "dnwrap");
        step(1,1,0,0,0,4'h0, 0, 5'b01100, 4'd6, 4'b0101, 0,0,0, "dn2");
        // illegal load, sticky err, recovery, clear
        step(1,0,1,0,1,4'h5, 0, 5'b00101, 4'd0, 4'b0000, 1,0,0, "ldill");
        step(1,0,1,0,0,4'h0, 0, 5'b00101, 4'd0, 4'b0000, 1,1,0, "illerr");
        step(1,1,0,0,0,4'h0, 0, 5'b00000, 4'd0, 4'b0000, 0,1,0, "recover");
        step(1,0,1,0,0,4'h0, 0, 5'b00000, 4'd0, 4'b0000, 0,1,0, "errhold");
        step(1,0,1,1,0,4'h0, 0, 5'b00000, 4'd0, 4'b0000, 0,0,0, "errclr");
        // priority clr > ld > en
        step(1,0,1,0,1,4'h7, 0, 5'b00111, 4'd3, 4'b0010, 0,0,0, "ld0111");
        step(1,1,1,1,1,4'hF, 0, 5'b00000, 4'd0, 4'b0000, 0,0,0, "clrwins");
        step(1,1,1,0,1,4'h3, 0, 5'b00011, 4'd2, 4'b0011, 0,0,0, "ldwins");
        // JW=5 up count, 10 states
        step(1,0,1,1,0,4'h0, 1, 5'b00000, 4'd0, 4'b0000, 0,0,0, "w5clr");
        step(1,1,1,0,0,4'h0, 1, 5'b00001, 4'd1, 4'b0001, 0,0,0, "w5s1");
        step(1,1,1,0,0,4'h0, 1, 5'b00011, 4'd2, 4'b0011, 0,0,0, "w5s2");
        step(1,1,1,0,0,4'h0, 1, 5'b00111, 4'd3, 4'b0010, 0,0,0, "w5s3");
        step(1,1,1,0,0,4'h0, 1, 5'b01111, 4'd4, 4'b0110, 0,0,0, "w5s4");
        step(1,1,1,0,0,4'h0, 1, 5'b11111, 4'd5, 4'b0111, 0,0,0, "w5s5");
        step(1,1,1,0,0,4'h0, 1, 5'b11110, 4'd6, 4'b0101, 0,0,0, "w5s6");
        step(1,1,1,0,0,4'h0, 1, 5'b11100, 4'd7, 4'b0100, 0,0,0, "w5s7");
        step(1,1,1,0,0,4'h0, 1, 5'b11000, 4'd8, 4'b1100, 0,0,0, "w5s8");
        step(1,1,1,0,0,4'h0, 1, 5'b10000, 4'd9, 4'b1101, 0,0,0, "w5s9");
        step(1,1,1,0,0,4'h0, 1, 5'b00000, 4'd0, 4'b0000, 0,0,1, "w5wrap");
        // async reset mid-count at 1110
        step(1,0,1,1,0,4'h0, 0, 5'b00000, 4'd0, 4'b0000, 0,0,0, "mclr");
        step(1,1,1,0,0,4'h0, 0, 5'b00001, 4'd1, 4'b0001, 0,0,0, "m1");
        step(1,1,1,0,0,4'h0, 0, 5'b00011, 4'd2, 4'b0011, 0,0,0, "m2");
        step(1,1,1,0,0,4'h0, 0, 5'b00111, 4'd3, 4'b0010, 0,0,0, "m3");
        step(1,1,1,0,0,4'h0, 0, 5'b01111, 4'd4, 4'b0110, 0,0,0, "m4");
        step(1,1,1,0,0,4'h0, 0, 5'b01110, 4'd5, 4'b0111, 0,0,0, "m5");
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async johnson", 8'(j4),   8'h00);
        chk("async index",   8'(idx4), 8'h00);
        chk("async gray",    8'(g4),   8'h00);
        chk("async illegal", 8'(ill4), 8'h00);
        chk("async err",     8'(err4), 8'h00);
        chk("async wrap",    8'(w4),   8'h00);
        step(1,1,1,0,0,4'h0, 0, 5'b00001, 4'd1, 4'b0001, 0,0,0, "resume");
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/johnson_gray_counter.md
Name: johnson_gray_counter

Overview:
- Parametrised Johnson (twisted-ring) counter with an integrated Johnson-to-Gray decoder. This is the sequential successor of the fixed 4-bit combinational converter.
- Generalised to any ring width JW (2*JW states). Adds up/down count, synchronous clear, raw load, illegal-code detection with self-recovery, and a wrap pulse.
- Used as a glitch-safe phase/position source wherever Gray-coded indices cross into other logic.

Parameters:
- JW, default 4: Johnson ring width in bits (>=2); sequence length is 2*JW.
- GW, default $clog2(2*JW): width of the Gray and index outputs. Derived; not overridden at instantiation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  step enable.
- dir  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear to state 0; also clears err.
- ld  in  1  synchronous load of ld_j.
- ld_j  in  JW  raw Johnson word to load; illegal words are accepted.
- johnson  out  JW  current ring state.
- index  out  GW  decoded position 0..2*JW-1.
- gray  out  GW  index ^ (index >> 1).
- illegal  out  1  current state is not a valid Johnson code.
- err  out  1  sticky illegal-state flag.
- wrap  out  1  one-cycle pulse on sequence wrap.

Behaviour:
- Reset (rst_n=0, async):
  - johnson=0, err=0, wrap=0.
  - Decoded outputs follow: index=0, gray=0, illegal=0.
- Edge priority per cycle: clr > ld > en. With none asserted, the state holds.
- clr:
  - johnson<=0, err<=0, wrap<=0.
- ld:
  - johnson<=ld_j, wrap<=0.
  - err is unaffected by the load itself.
- en, state valid:
  - Up: johnson <= {johnson[JW-2:0], ~johnson[JW-1]}.
  - Down: johnson <= {~johnson[0], johnson[JW-1:1]}.
- Validity rule: a code is valid iff it has the form 0..01..1 or 1..10..0 (this includes all-zero and all-one).
- Decode (combinational from state, zero latency):
  - If MSB=0: index = popcount(johnson).
  - If MSB=1: index = 2*JW - popcount(johnson).
  - gray = binary-to-Gray of index.
  - For JW=4 this reproduces g2=j3, g1=j1, g0=j2^j0.
- Illegal state:
  - illegal=1; index and gray are forced to 0.
  - At each clock edge while illegal=1 and clr=0: err<=1.
  - en in an illegal state: johnson<=0 regardless of dir; no wrap pulse.
- wrap (registered, asserted for the cycle after the step):
  - Up-step from index 2*JW-1 to 0.
  - Down-step from index 0 to 2*JW-1.
  - Otherwise 0.
- Gray property: consecutive states differ by one Gray bit, including the wrap step, only when 2*JW is a power of 2. Otherwise the wrap step is multi-bit; this is documented, not corrected.
- Reset mid-count: immediate async return to the reset values above; counting resumes from 0 on the first en after rst_n deasserts.

Optional Feature:
- Macro: JG_OUT_REG_EN.
- Defined: index, gray and illegal are registered.
  - They are one cycle behind johnson.
  - wrap is delayed one extra cycle so it stays aligned with gray.
  - The registered outputs reset to 0.
- Undefined: the outputs are combinational from the state register as described above.

Decomposition:
- Package jg_pkg:
  - JW default constant.
  - Index-width function (clog2).
  - bin2gray function.
  - johnson_valid function.
  - johnson_to_index function.
- Sub-module johnson_decode (JW parameter, purely combinational):
  - Inputs: Johnson word.
  - Outputs: index, gray, illegal.
  - Instantiated once on the state register. It is reusable standalone as the generalised converter.
- Top level holds the state register, priority mux, err and wrap logic, and the optional output stage.

Test Plan:
- JW=4, reset then en=1, dir=1 for 8 cycles -> johnson 0000,0001,0011,0111,1111,1110,1100,1000; gray 000,001,011,010,110,111,101,100; wrap=1 exactly in the cycle after the step 1000->0000.
- JW=4, reset, en=1, dir=0 for 1 cycle -> johnson=1000, index=7, gray=100, wrap pulses once; a further down-step -> 1100, gray=101.
- JW=4, ld=1, ld_j=0101 -> illegal=1, gray=000, err=1 after the next edge; then en=1 -> johnson=0000, illegal=0, err stays 1 until clr=1 clears it.
- clr=1, ld=1, en=1 in the same cycle with johnson=0111 -> johnson=0000, err=0 (clr wins); ld=1, en=1 with ld_j=0011 -> johnson=0011 (ld wins).
- JW=5, up-count from 0 -> 10 states; index 9 (johnson 10000) gray=1101; wrap to 0 gives gray 0000 with wrap=1.
- Pulse rst_n low mid-count at johnson=1110 -> all outputs 0 immediately, without waiting for a clock edge; with JG_OUT_REG_EN defined, gray lags johnson by one cycle throughout the first scenario.
